// File: rtl/enc_sched_pkg.sv
// Shared types and default constants for the encoder channel sequencer.
package enc_sched_pkg;

    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned CH_W    = 3;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 64;

    // Per-slot processing sequence.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT_DONE,
        ST_WRITE,
        ST_STROBE
    } state_e;

endpackage

// File: rtl/enc_sync_edge.sv
// Two-flop synchroniser with a registered previous sample for rising-edge detection.
module enc_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the asynchronous input through the synchroniser and history flop.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level  = sync_q;
    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/enc_ch_sched.sv
// Per-channel sequencer: tracks the slot index and runs settle/start/wait/write/strobe per slot.
module enc_ch_sched
    import enc_sched_pkg::*;
#(
    parameter int unsigned NUM_CH  = enc_sched_pkg::NUM_CH,
    parameter int unsigned CH_W    = enc_sched_pkg::CH_W,
    parameter int unsigned SETTLE  = enc_sched_pkg::SETTLE,
    parameter int unsigned TIMEOUT = enc_sched_pkg::TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fsync_in,
    input  logic            ch_clk_in,
    input  logic            fa_done,
    output logic            fa_start,
    output logic            dly_strb,
    output logic            rf_wr,
    output logic [CH_W-1:0] rf_wr_addr,
    output logic            rf_rd,
    output logic [CH_W-1:0] rf_rd_addr,
    output logic [CH_W-1:0] ch_num,
    output logic            busy,
    output logic            overrun,
    output logic            timeout
);

    localparam int unsigned CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic ch_lvl, ch_rise;
    logic fs_lvl, fs_rise;
    logic unused_sync;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_num_q, ch_num_d;
    logic [CH_W-1:0]   svc_ch_q, svc_ch_d;
    logic [CH_W-1:0]   rf_rd_addr_q, rf_rd_addr_d;
    logic [CH_W-1:0]   rf_wr_addr_q, rf_wr_addr_d;
    logic              rf_rd_q, rf_rd_d;
    logic              rf_wr_q, rf_wr_d;
    logic              fa_start_q, fa_start_d;
    logic              dly_strb_q, dly_strb_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    enc_sync_edge u_sync_ch (
        .clk      (clk),
        .reset    (reset),
        .async_in (ch_clk_in),
        .level    (ch_lvl),
        .rise_c   (ch_rise)
    );

    enc_sync_edge u_sync_fs (
        .clk      (clk),
        .reset    (reset),
        .async_in (fsync_in),
        .level    (fs_lvl),
        .rise_c   (fs_rise)
    );

    // Slot numbering keys off the frame sync level, not its edge.
    assign unused_sync = ch_lvl ^ fs_rise;

    // Channel index and RF read of the previous channel on every slot edge.
    always_comb begin
        ch_num_d     = ch_num_q;
        rf_rd_d      = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        if (ch_rise) begin
            ch_num_d     = fs_lvl ? '0 : ch_num_q + CH_W'(1);
            rf_rd_d      = 1'b1;
            rf_rd_addr_d = ch_num_d - CH_W'(1);
        end
    end

    // Sequence FSM next state, counters, sticky flags and registered pulse outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        svc_ch_d     = svc_ch_q;
        timeout_d    = timeout_q;
        overrun_d    = overrun_q | (ch_rise && (state_q != ST_IDLE));
        rf_wr_addr_d = rf_wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (ch_rise) begin
                    state_d  = ST_SETTLE;
                    cnt_d    = CNT_W'(SETTLE - 1);
                    svc_ch_d = ch_num_d;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
                cnt_d   = '0;
            end
            ST_WAIT_DONE: begin
                if (fa_done) begin
                    state_d = ST_WRITE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Write back to the channel this sequence started on, even if an overrun
        // edge has since advanced ch_num.
        if (state_d == ST_WRITE) begin
            rf_wr_addr_d = svc_ch_q;
        end

        fa_start_d = (state_d == ST_START);
        rf_wr_d    = (state_d == ST_WRITE);
        dly_strb_d = (state_d == ST_STROBE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ch_num_q     <= CH_W'(NUM_CH - 1);
            svc_ch_q     <= '0;
            rf_rd_addr_q <= '0;
            rf_wr_addr_q <= '0;
            rf_rd_q      <= 1'b0;
            rf_wr_q      <= 1'b0;
            fa_start_q   <= 1'b0;
            dly_strb_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_num_q     <= ch_num_d;
            svc_ch_q     <= svc_ch_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_rd_q      <= rf_rd_d;
            rf_wr_q      <= rf_wr_d;
            fa_start_q   <= fa_start_d;
            dly_strb_q   <= dly_strb_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign fa_start   = fa_start_q;
    assign dly_strb   = dly_strb_q;
    assign rf_wr      = rf_wr_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_rd      = rf_rd_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign ch_num     = ch_num_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule
